// File: rtl/activity_mark_16.sv
// Double-banked 16-element activity bitmap: marks accumulate in next_bank,
// a drain snapshots them into active_bank and streams indices lowest-first.
module activity_mark_16 (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       mark_valid,
  input  logic [3:0] mark_idx,
  input  logic       drain_start,
  output logic       out_valid,
  output logic [3:0] out_idx,
  input  logic       out_ready,
  output logic       done,
  output logic       busy,
  output logic [4:0] next_count
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t      state_reg, state_next;
  logic [15:0] next_bank_reg, next_bank_next;
  logic [15:0] active_bank_reg, active_bank_next;
  logic        out_valid_reg, out_valid_next;
  logic [3:0]  out_idx_reg, out_idx_next;
  logic [4:0]  next_count_reg, next_count_next;

  logic [15:0] mark_vec;
  logic [15:0] rem;

  function automatic logic [3:0] lowest_bit(input logic [15:0] b);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (b[i]) r = 4'(i);
    end
    return r;
  endfunction

  function automatic logic [4:0] popcount16(input logic [15:0] b);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) begin
      c = c + 5'(b[i]);
    end
    return c;
  endfunction

  assign mark_vec = mark_valid ? (16'd1 << mark_idx) : 16'd0;
  assign rem      = active_bank_reg & ~(16'd1 << out_idx_reg);

  always_comb begin
    state_next       = state_reg;
    next_bank_next   = next_bank_reg | mark_vec;
    active_bank_next = active_bank_reg;
    out_valid_next   = out_valid_reg;
    out_idx_next     = out_idx_reg;

    unique case (state_reg)
      IDLE: begin
        if (drain_start) begin
          // A mark coincident with the snapshot joins this pass.
          active_bank_next = next_bank_reg | mark_vec;
          next_bank_next   = 16'd0;
          state_next       = LOAD;
        end
      end
      LOAD: begin
        if (active_bank_reg != 16'd0) begin
          out_idx_next   = lowest_bit(active_bank_reg);
          out_valid_next = 1'b1;
          state_next     = DRAIN;
        end else begin
          state_next = DONE;
        end
      end
      DRAIN: begin
        if (out_valid_reg && out_ready) begin
          active_bank_next = rem;
          if (rem != 16'd0) begin
            out_idx_next = lowest_bit(rem);
          end else begin
            out_valid_next = 1'b0;
            state_next     = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (clear) begin
      state_next       = IDLE;
      next_bank_next   = 16'd0;
      active_bank_next = 16'd0;
      out_valid_next   = 1'b0;
    end

    next_count_next = popcount16(next_bank_next);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      next_bank_reg   <= 16'd0;
      active_bank_reg <= 16'd0;
      out_valid_reg   <= 1'b0;
      out_idx_reg     <= 4'd0;
      next_count_reg  <= 5'd0;
    end else begin
      state_reg       <= state_next;
      next_bank_reg   <= next_bank_next;
      active_bank_reg <= active_bank_next;
      out_valid_reg   <= out_valid_next;
      out_idx_reg     <= out_idx_next;
      next_count_reg  <= next_count_next;
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_idx    = out_idx_reg;
  assign next_count = next_count_reg;
  assign done       = (state_reg == DONE);
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_activity_mark_16.sv
// Bench for activity_mark_16: per-cycle vector table plus hand sequences,
// with a queue of expected drain indices checked on every accept.
module tb_activity_mark_16;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       mark_valid;
  logic [3:0] mark_idx;
  logic       drain_start;
  logic       out_valid;
  logic [3:0] out_idx;
  logic       out_ready;
  logic       done;
  logic       busy;
  logic [4:0] next_count;

  int pass_cnt = 0;
  int total_cnt = 0;
  int sb[$];

  always #5 clk = ~clk;

  activity_mark_16 dut (
    .clk(clk), .reset(reset), .clear(clear),
    .mark_valid(mark_valid), .mark_idx(mark_idx), .drain_start(drain_start),
    .out_valid(out_valid), .out_idx(out_idx), .out_ready(out_ready),
    .done(done), .busy(busy), .next_count(next_count)
  );

  typedef struct {
    logic        mv;
    logic [3:0]  mi;
    logic        ds;
    logic        rdy;
    logic [15:0] set;
    logic        e_ov;
    logic [3:0]  e_idx;
    logic        e_done;
    logic        e_busy;
    logic [4:0]  e_nc;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) begin
      pass_cnt++;
      $display("check %s: got %0d expected %0d ok", name, act, exp);
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_set(input logic [15:0] s);
    for (int i = 0; i < 16; i++) begin
      if (s[i]) sb.push_back(i);
    end
  endtask

  task automatic idle_inputs;
    mark_valid  = 1'b0;
    mark_idx    = 4'd0;
    drain_start = 1'b0;
    clear       = 1'b0;
  endtask

  task automatic do_mark(input logic [3:0] idx);
    mark_valid = 1'b1;
    mark_idx   = idx;
    tick();
    mark_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", int'(done), 1);
  endtask

  // Scoreboard: every accepted index must match the head of the queue.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      total_cnt++;
      if (sb.size() == 0) begin
        $display("FAIL sb_extra: got idx %0d expected no output", out_idx);
      end else begin
        int e;
        e = sb.pop_front();
        if (int'(out_idx) == e) begin
          pass_cnt++;
          $display("accept idx %0d expected %0d ok", out_idx, e);
        end else begin
          $display("FAIL sb_idx: got %0d expected %0d", out_idx, e);
        end
      end
    end
  end

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b1, 4'd3,  1'b0, 1'b1, 16'h0,    1'b0, 4'd0,  1'b0, 1'b0, 5'd1};
    vecs[1] = '{1'b1, 4'd0,  1'b0, 1'b1, 16'h0,    1'b0, 4'd0,  1'b0, 1'b0, 5'd2};
    vecs[2] = '{1'b1, 4'd15, 1'b0, 1'b1, 16'h0,    1'b0, 4'd0,  1'b0, 1'b0, 5'd3};
    vecs[3] = '{1'b1, 4'd3,  1'b0, 1'b1, 16'h0,    1'b0, 4'd0,  1'b0, 1'b0, 5'd3};
    vecs[4] = '{1'b0, 4'd0,  1'b1, 1'b1, 16'h8009, 1'b0, 4'd0,  1'b0, 1'b1, 5'd0};
    vecs[5] = '{1'b0, 4'd0,  1'b0, 1'b1, 16'h0,    1'b1, 4'd0,  1'b0, 1'b1, 5'd0};
    vecs[6] = '{1'b0, 4'd0,  1'b0, 1'b1, 16'h0,    1'b1, 4'd3,  1'b0, 1'b1, 5'd0};
    vecs[7] = '{1'b0, 4'd0,  1'b0, 1'b1, 16'h0,    1'b1, 4'd15, 1'b0, 1'b1, 5'd0};
    vecs[8] = '{1'b0, 4'd0,  1'b0, 1'b1, 16'h0,    1'b0, 4'd0,  1'b1, 1'b1, 5'd0};
    vecs[9] = '{1'b0, 4'd0,  1'b0, 1'b1, 16'h0,    1'b0, 4'd0,  1'b0, 1'b0, 5'd0};

    idle_inputs();
    out_ready = 1'b1;
    reset = 1'b1;
    #3;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_next_count", int'(next_count), 0);
    tick();
    tick();
    reset = 1'b0;

    // Marks 3,0,15,3 then a full drain with out_ready held high.
    for (int r = 0; r < 10; r++) begin
      mark_valid  = vecs[r].mv;
      mark_idx    = vecs[r].mi;
      drain_start = vecs[r].ds;
      out_ready   = vecs[r].rdy;
      if (vecs[r].ds) push_set(vecs[r].set);
      tick();
      chk($sformatf("vec%0d_out_valid", r), int'(out_valid), int'(vecs[r].e_ov));
      if (vecs[r].e_ov) chk($sformatf("vec%0d_out_idx", r), int'(out_idx), int'(vecs[r].e_idx));
      chk($sformatf("vec%0d_done", r), int'(done), int'(vecs[r].e_done));
      chk($sformatf("vec%0d_busy", r), int'(busy), int'(vecs[r].e_busy));
      chk($sformatf("vec%0d_next_count", r), int'(next_count), int'(vecs[r].e_nc));
    end
    idle_inputs();

    // Backpressure: index 5 must hold for six stalled cycles.
    do_mark(4'd5);
    do_mark(4'd9);
    out_ready = 1'b0;
    drain_start = 1'b1;
    push_set(16'h0220);
    tick();
    drain_start = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("bp%0d_out_valid", i), int'(out_valid), 1);
      chk($sformatf("bp%0d_out_idx", i), int'(out_idx), 5);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_next_idx", int'(out_idx), 9);
    chk("bp_next_valid", int'(out_valid), 1);
    wait_done(10);
    tick();
    chk("bp_idle", int'(busy), 0);

    // Double buffering: mark and drain_start during DRAIN go to the next pass.
    do_mark(4'd2);
    drain_start = 1'b1;
    push_set(16'h0004);
    tick();
    drain_start = 1'b0;
    tick();
    chk("db_first_idx", int'(out_idx), 2);
    mark_valid = 1'b1;
    mark_idx = 4'd7;
    drain_start = 1'b1;
    tick();
    idle_inputs();
    chk("db_done", int'(done), 1);
    chk("db_next_count", int'(next_count), 1);
    tick();
    chk("db_idle", int'(busy), 0);
    drain_start = 1'b1;
    push_set(16'h0080);
    tick();
    drain_start = 1'b0;
    wait_done(10);
    tick();

    // Coincident mark joins the pass; then an empty pass.
    mark_valid = 1'b1;
    mark_idx = 4'd11;
    drain_start = 1'b1;
    push_set(16'h0800);
    tick();
    idle_inputs();
    chk("coin_next_count", int'(next_count), 0);
    wait_done(10);
    tick();
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    chk("empty_busy", int'(busy), 1);
    tick();
    chk("empty_done", int'(done), 1);
    chk("empty_out_valid", int'(out_valid), 0);
    tick();
    chk("empty_idle", int'(busy), 0);

    // Abort with clear after index 1 is accepted.
    do_mark(4'd1);
    do_mark(4'd4);
    do_mark(4'd6);
    drain_start = 1'b1;
    push_set(16'h0052);
    tick();
    drain_start = 1'b0;
    tick();
    tick();
    out_ready = 1'b0;
    clear = 1'b1;
    mark_valid = 1'b1;
    mark_idx = 4'd8;
    tick();
    idle_inputs();
    sb.delete();
    chk("clr_out_valid", int'(out_valid), 0);
    chk("clr_busy", int'(busy), 0);
    chk("clr_next_count", int'(next_count), 0);
    chk("clr_done", int'(done), 0);
    tick();
    chk("clr_no_late_done", int'(done), 0);
    out_ready = 1'b1;

    // Abort with asynchronous reset mid-cycle.
    do_mark(4'd1);
    do_mark(4'd4);
    do_mark(4'd6);
    drain_start = 1'b1;
    push_set(16'h0052);
    tick();
    drain_start = 1'b0;
    tick();
    tick();
    out_ready = 1'b0;
    chk("ar_pre_valid", int'(out_valid), 1);
    #2;
    reset = 1'b1;
    #1;
    sb.delete();
    chk("ar_out_valid", int'(out_valid), 0);
    chk("ar_out_idx", int'(out_idx), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_done", int'(done), 0);
    chk("ar_next_count", int'(next_count), 0);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("ar_after_busy", int'(busy), 0);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
